// File: rtl/icw_write_sequencer.sv
// Turns raw CPU write cycles into one-cycle ICW/OCW write strobes and tracks the
// ICW1 -> ICW2 -> (ICW3) -> (ICW4) initialization sequence of the interrupt controller.
//
// state      | meaning
// WAIT_ICW1  | out of reset, only ICW1 accepted
// WAIT_ICW2  | ICW1 seen, next A0=1 write is ICW2
// WAIT_ICW3  | cascade mode, next A0=1 write is ICW3
// WAIT_ICW4  | IC4 set, next A0=1 write is ICW4
// READY      | initialized, A0=1 -> OCW1, A0=0 -> OCW2/OCW3
module icw_write_sequencer #(
  parameter bit WRITE_ON_FALL = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       write,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic [2:0] command_state,
  output logic       initialization_complete
);

  localparam logic [2:0] S_WAIT_ICW1 = 3'd0;
  localparam logic [2:0] S_WAIT_ICW2 = 3'd1;
  localparam logic [2:0] S_WAIT_ICW3 = 3'd2;
  localparam logic [2:0] S_WAIT_ICW4 = 3'd3;
  localparam logic [2:0] S_READY     = 3'd4;

  logic       r_write_q;
  logic       r_armed;
  logic       r_hold_addr;
  logic [7:0] r_hold_data;
  logic [2:0] r_state;
  logic       r_sngl;
  logic       r_ic4;
  logic [7:0] r_data;
  logic [6:0] r_strobe;

  logic       w_rise;
  logic       w_fall;
  logic       w_edge;
  logic       w_addr;
  logic [7:0] w_data;
  logic [6:0] w_strobe_next;
  logic [2:0] w_state_next;
  logic       w_load;
  logic       w_icw1;

  assign w_rise = ~r_write_q & write;
  assign w_fall = r_write_q & ~write;

  // A write level left over from reset must not complete as a command: the end
  // of a write only counts once write has been seen idle since reset.
  assign w_edge = WRITE_ON_FALL ? (w_fall & r_armed) : w_rise;
  assign w_addr = WRITE_ON_FALL ? r_hold_addr : address;
  assign w_data = WRITE_ON_FALL ? r_hold_data : data_bus_in;
  assign w_icw1 = ~w_addr & w_data[4];

  always_comb begin
    w_strobe_next = 7'b0;
    w_state_next  = r_state;
    w_load        = 1'b0;
    if (w_edge) begin
      if (w_icw1) begin
        w_strobe_next[0] = 1'b1;
        w_load           = 1'b1;
        w_state_next     = S_WAIT_ICW2;
      end else begin
        case (r_state)
          S_WAIT_ICW2: begin
            if (w_addr) begin
              w_strobe_next[1] = 1'b1;
              w_load           = 1'b1;
              if (!r_sngl)    w_state_next = S_WAIT_ICW3;
              else if (r_ic4) w_state_next = S_WAIT_ICW4;
              else            w_state_next = S_READY;
            end
          end
          S_WAIT_ICW3: begin
            if (w_addr) begin
              w_strobe_next[2] = 1'b1;
              w_load           = 1'b1;
              w_state_next     = r_ic4 ? S_WAIT_ICW4 : S_READY;
            end
          end
          S_WAIT_ICW4: begin
            if (w_addr) begin
              w_strobe_next[3] = 1'b1;
              w_load           = 1'b1;
              w_state_next     = S_READY;
            end
          end
          S_READY: begin
            w_load = 1'b1;
            if (w_addr)          w_strobe_next[4] = 1'b1;
            else if (!w_data[3]) w_strobe_next[5] = 1'b1;
            else                 w_strobe_next[6] = 1'b1;
          end
          // WAIT_ICW1 and the unused encodings accept nothing but ICW1.
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_write_q   <= 1'b0;
      r_armed     <= 1'b0;
      r_hold_addr <= 1'b0;
      r_hold_data <= 8'h00;
    end else begin
      r_write_q <= write;
      if (!write) r_armed <= 1'b1;
      if (write) begin
        r_hold_addr <= address;
        r_hold_data <= data_bus_in;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_WAIT_ICW1;
      r_sngl   <= 1'b0;
      r_ic4    <= 1'b0;
      r_data   <= 8'h00;
      r_strobe <= 7'b0;
    end else begin
      r_strobe <= w_strobe_next;
      r_state  <= w_state_next;
      if (w_load) r_data <= w_data;
      if (w_edge && w_icw1) begin
        r_sngl <= w_data[1];
        r_ic4  <= w_data[0];
      end
    end
  end

  assign internal_data_bus              = r_data;
  assign write_initial_command_word_1   = r_strobe[0];
  assign write_initial_command_word_2   = r_strobe[1];
  assign write_initial_command_word_3   = r_strobe[2];
  assign write_initial_command_word_4   = r_strobe[3];
  assign write_operation_control_word_1 = r_strobe[4];
  assign write_operation_control_word_2 = r_strobe[5];
  assign write_operation_control_word_3 = r_strobe[6];
  assign command_state                  = r_state;
  assign initialization_complete        = (r_state == S_READY);

endmodule

// File: tb/tb_icw_write_sequencer.sv
// Directed bench for icw_write_sequencer (WRITE_ON_FALL=1) with a per-cycle compare
// against a command-level model of the initialization sequence.
module tb_icw_write_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       write;
  logic       address;
  logic [7:0] data_bus_in;
  logic [7:0] internal_data_bus;
  logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
  logic [2:0] command_state;
  logic       initialization_complete;

  icw_write_sequencer dut (
    .clock                          (clock),
    .reset                          (reset),
    .write                          (write),
    .address                        (address),
    .data_bus_in                    (data_bus_in),
    .internal_data_bus              (internal_data_bus),
    .write_initial_command_word_1   (icw1),
    .write_initial_command_word_2   (icw2),
    .write_initial_command_word_3   (icw3),
    .write_initial_command_word_4   (icw4),
    .write_operation_control_word_1 (ocw1),
    .write_operation_control_word_2 (ocw2),
    .write_operation_control_word_3 (ocw3),
    .command_state                  (command_state),
    .initialization_complete        (initialization_complete)
  );

  always #5 clock = ~clock;

  wire [6:0] strb = {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};

  int total = 0;
  int bad   = 0;
  int n_strobes = 0;
  logic [6:0] last_strobe = 7'b0;
  bit check_en = 1'b0;

  // model: command-level state, updated when a write completes
  int         m_state;
  bit         m_sngl, m_ic4;
  logic [7:0] m_data;
  bit         p_valid;
  logic [6:0] p_strobe;
  int         p_state;
  logic [7:0] p_data;
  // what the outputs must show in the current cycle
  logic [6:0] e_strobe;
  int         e_state;
  logic [7:0] e_data;

  task automatic model_reset();
    m_state = 0; m_sngl = 0; m_ic4 = 0; m_data = 8'h00;
    p_valid = 0;
    e_strobe = 7'b0; e_state = 0; e_data = 8'h00;
  endtask

  task automatic model_apply(input bit a, input logic [7:0] d);
    logic [6:0] s;
    s = 7'b0;
    if (!a && d[4]) begin
      s = 7'b0000001; m_sngl = d[1]; m_ic4 = d[0]; m_state = 1; m_data = d;
    end else if (m_state == 1 && a) begin
      s = 7'b0000010; m_data = d;
      m_state = !m_sngl ? 2 : (m_ic4 ? 3 : 4);
    end else if (m_state == 2 && a) begin
      s = 7'b0000100; m_data = d; m_state = m_ic4 ? 3 : 4;
    end else if (m_state == 3 && a) begin
      s = 7'b0001000; m_data = d; m_state = 4;
    end else if (m_state == 4) begin
      m_data = d;
      s = a ? 7'b0010000 : (d[3] ? 7'b1000000 : 7'b0100000);
    end
    p_strobe = s; p_state = m_state; p_data = m_data; p_valid = 1;
  endtask

  always @(posedge clock) begin
    e_strobe = 7'b0;
    if (p_valid && !reset) begin
      e_strobe = p_strobe; e_state = p_state; e_data = p_data; p_valid = 0;
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      total++;
      if (strb !== e_strobe || command_state !== e_state[2:0] ||
          internal_data_bus !== e_data || initialization_complete !== (e_state == 4)) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t got strb=%b st=%0d data=%h cmp=%b want strb=%b st=%0d data=%h cmp=%b",
                 $time, strb, command_state, internal_data_bus, initialization_complete,
                 e_strobe, e_state, e_data, (e_state == 4));
      end
      if (|strb) begin
        n_strobes++;
        last_strobe = strb;
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_write(input bit a, input logic [7:0] d, input int len);
    tick();
    address = a; data_bus_in = d; write = 1'b1;
    repeat (len) tick();
    write = 1'b0; address = ~a; data_bus_in = ~d;
    model_apply(a, d);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    reset = 1'b1; write = 1'b0; address = 1'b0; data_bus_in = 8'h00;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    check_en = 1'b1;
    tick();
    chk("reset_state", command_state, 0);
    chk("reset_data", internal_data_bus, 8'h00);

    // writes before ICW1 are ignored
    n0 = n_strobes;
    do_write(1'b1, 8'hAA, 2);
    do_write(1'b0, 8'h08, 2);
    chk("preinit_no_strobe", n_strobes - n0, 0);
    chk("preinit_state", command_state, 0);
    chk("preinit_data", internal_data_bus, 8'h00);

    // single, no ICW4
    do_write(1'b0, 8'h12, 2);
    chk("t2_icw1", last_strobe, 7'b0000001);
    chk("t2_state1", command_state, 1);
    do_write(1'b1, 8'h20, 2);
    chk("t2_icw2", last_strobe, 7'b0000010);
    chk("t2_state4", command_state, 4);
    chk("t2_complete", initialization_complete, 1);
    do_write(1'b1, 8'hFF, 2);
    chk("t2_ocw1", last_strobe, 7'b0010000);
    chk("t2_ocw1_data", internal_data_bus, 8'hFF);

    // READY decode of A0=0 writes
    do_write(1'b0, 8'h20, 2);
    chk("t5_ocw2", last_strobe, 7'b0100000);
    do_write(1'b0, 8'h08, 2);
    chk("t5_ocw3", last_strobe, 7'b1000000);
    chk("t5_data", internal_data_bus, 8'h08);

    // async reset mid-cycle takes effect immediately
    @(posedge clock); #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t1_state", command_state, 0);
    chk("t1_data", internal_data_bus, 8'h00);
    chk("t1_strobes", strb, 0);
    tick();
    reset = 1'b0;
    tick();

    // cascade with ICW4
    do_write(1'b0, 8'h11, 2);
    chk("t3_state1", command_state, 1);
    do_write(1'b1, 8'h40, 2);
    chk("t3_state2", command_state, 2);
    do_write(1'b1, 8'h04, 2);
    chk("t3_icw3", last_strobe, 7'b0000100);
    chk("t3_state3", command_state, 3);
    do_write(1'b1, 8'h01, 2);
    chk("t3_icw4", last_strobe, 7'b0001000);
    chk("t3_state4", command_state, 4);
    chk("t3_data", internal_data_bus, 8'h01);

    // restart from READY and mid-sequence
    do_write(1'b0, 8'h11, 2);
    chk("t4_restart_ready", command_state, 1);
    do_write(1'b1, 8'h40, 2);
    n0 = n_strobes;
    do_write(1'b0, 8'h08, 2);
    chk("t4_a0_low_ignored", n_strobes - n0, 0);
    do_write(1'b0, 8'h13, 2);
    chk("t4_icw1", last_strobe, 7'b0000001);
    chk("t4_state1", command_state, 1);
    chk("t4_not_complete", initialization_complete, 0);
    do_write(1'b1, 8'h20, 2);
    chk("t4_icw2_to_icw4", command_state, 3);
    do_write(1'b1, 8'h03, 2);
    chk("t4_ready", command_state, 4);

    // long and short pulses
    n0 = n_strobes;
    do_write(1'b1, 8'h55, 10);
    chk("t6_long_one", n_strobes - n0, 1);
    n0 = n_strobes;
    do_write(1'b1, 8'h3C, 1);
    chk("t6_short_one", n_strobes - n0, 1);

    // reset during a write: the leftover level produces no strobe
    n0 = n_strobes;
    tick();
    address = 1'b0; data_bus_in = 8'h13; write = 1'b1;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    write = 1'b0;
    repeat (4) tick();
    chk("t6_reset_no_strobe", n_strobes - n0, 0);
    chk("t6_reset_state", command_state, 0);

    // fresh write after that is accepted
    do_write(1'b0, 8'h12, 2);
    chk("t6_fresh_icw1", last_strobe, 7'b0000001);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
